// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop rx synchroniser, mid-bit start validation,
// centre sampling of LSB-first data, stop-bit check with framing-error flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | counting to mid start bit to reject glitches
// S_DATA  | sampling DBIT data bits at their centres
// S_STOP  | waiting out the stop interval, then deliver byte
module uart_rx #(
  parameter int DBIT          = 8,
  parameter int S_TICK_LIM    = 16,
  parameter int STOP_BITS_LIM = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [4:0] START_MID = 5'(S_TICK_LIM / 2 - 1);
  localparam logic [4:0] BIT_LAST  = 5'(S_TICK_LIM - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS_LIM - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam int         SHIFT     = 8 - DBIT;

  state_t     state;
  logic       rx_meta;
  logic       rx_s;
  logic [4:0] s_cnt;
  logic [2:0] n_cnt;
  logic [7:0] b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            s_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (s_cnt == START_MID) begin
              s_cnt <= '0;
              if (!rx_s) begin
                state <= S_DATA;
                n_cnt <= '0;
              end else begin
                // false start: drop back without touching outputs
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_LAST) begin
              s_cnt <= '0;
              b     <= {rx_s, b[7:1]};
              if (n_cnt == N_LAST) begin
                state <= S_STOP;
              end else begin
                n_cnt <= n_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        S_STOP: begin
          if (s_tick) begin
            if (s_cnt == STOP_LAST) begin
              // half-bit start offset puts this sample mid final stop bit
              s_cnt        <= '0;
              dout         <= b >> SHIFT;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= S_IDLE;
              busy         <= 1'b0;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          s_cnt <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8N1 instance plus a 7-bit, 2-stop instance,
// both fed from one 1-in-4 s_tick generator.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic       sel7;
  logic       rx8, rx7;
  logic       s_tick = 1'b0;
  logic [1:0] div = '0;
  int         tick_num = 0;

  logic [7:0] dout8, dout7;
  logic       done8, done7, fe8, fe7, busy8, busy7;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt8 = 0, cnt7 = 0;
  int tick8_cap = 0, tick7_cap = 0;
  int start_tick = 0;
  int prev;

  assign rx8 = sel7 ? 1'b1 : rx_line;
  assign rx7 = sel7 ? rx_line : 1'b1;

  uart_rx u_dut8 (
    .clk(clk), .reset(reset), .rx(rx8), .s_tick(s_tick),
    .dout(dout8), .rx_done_tick(done8), .frame_err(fe8), .busy(busy8)
  );

  uart_rx #(.DBIT(7), .S_TICK_LIM(16), .STOP_BITS_LIM(32)) u_dut7 (
    .clk(clk), .reset(reset), .rx(rx7), .s_tick(s_tick),
    .dout(dout7), .rx_done_tick(done7), .frame_err(fe7), .busy(busy7)
  );

  always #5 clk = ~clk;

  // s_tick high for one clk in every four; tick_num counts ticks begun
  always @(posedge clk) begin
    div    <= div + 2'd1;
    s_tick <= (div == 2'd3);
    if (div == 2'd3) tick_num <= tick_num + 1;
  end

  always @(negedge clk) begin
    if (done8) begin
      cnt8      <= cnt8 + 1;
      tick8_cap <= tick_num;
    end
    if (done7) begin
      cnt7      <= cnt7 + 1;
      tick7_cap <= tick_num;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (!s_tick);
    end
  endtask

  // 16 ticks per bit; abort_bit >= 0 pulses reset mid that data bit and stops
  task automatic send_frame(input logic use7, input logic [7:0] data, input int nbits,
                            input logic stop_val, input int stop_ticks, input int abort_bit);
    sel7       = use7;
    start_tick = tick_num;
    rx_line    = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      rx_line = data[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        rx_line = 1'b1;
        wait_ticks(8);
        return;
      end
      wait_ticks(16);
    end
    rx_line = stop_val;
    wait_ticks(stop_ticks);
    rx_line = 1'b1;
  endtask

  task automatic frame8(input logic [7:0] data, input string tag);
    prev = cnt8;
    send_frame(1'b0, data, 8, 1'b1, 16, -1);
    check_val({tag, "_pulses"}, 32'(cnt8 - prev), 32'd1);
    check_val({tag, "_dout"}, {24'd0, dout8}, {24'd0, data});
    check_val({tag, "_ferr"}, {31'd0, fe8}, 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    rx_line = 1'b1;
    sel7    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_dout", {24'd0, dout8}, 32'd0);
    check_val("rst_done", {31'd0, done8}, 32'd0);
    check_val("rst_ferr", {31'd0, fe8}, 32'd0);
    check_val("rst_busy", {31'd0, busy8}, 32'd0);
    reset = 1'b1;
    wait_ticks(4);

    // nominal 0xA5; 8 start + 8*16 data + 16 stop ticks to the pulse
    frame8(8'hA5, "nom");
    check_val("nom_busy", {31'd0, busy8}, 32'd0);
    check_val("nom_latency", 32'(tick8_cap - start_tick), 32'd152);

    frame8(8'h00, "b2b0");
    frame8(8'hFF, "b2b1");
    frame8(8'h3C, "b2b2");

    // glitch shorter than half a bit
    prev    = cnt8;
    rx_line = 1'b0;
    wait_ticks(2);
    check_val("glitch_busy_hi", {31'd0, busy8}, 32'd1);
    wait_ticks(1);
    rx_line = 1'b1;
    wait_ticks(20);
    check_val("glitch_busy_lo", {31'd0, busy8}, 32'd0);
    check_val("glitch_pulses", 32'(cnt8 - prev), 32'd0);
    check_val("glitch_dout", {24'd0, dout8}, 32'h3C);

    // low stop bit: byte delivered with frame_err; the still-low line then
    // looks like a new start, so let that spurious frame drain on an idle line
    prev = cnt8;
    send_frame(1'b0, 8'h5A, 8, 1'b0, 16, -1);
    check_val("ferr_pulses", 32'(cnt8 - prev), 32'd1);
    check_val("ferr_dout", {24'd0, dout8}, 32'h5A);
    check_val("ferr_flag", {31'd0, fe8}, 32'd1);
    wait_ticks(200);
    check_val("ferr_drain_busy", {31'd0, busy8}, 32'd0);
    frame8(8'h11, "clean");

    // reset during data bit 4 of 0xC3
    prev = cnt8;
    send_frame(1'b0, 8'hC3, 8, 1'b1, 16, 4);
    check_val("rstmid_busy", {31'd0, busy8}, 32'd0);
    check_val("rstmid_pulses", 32'(cnt8 - prev), 32'd0);
    check_val("rstmid_dout", {24'd0, dout8}, 32'd0);
    wait_ticks(20);
    frame8(8'h81, "after_rst");

    // break: two complete all-zero frames within 320 ticks of low line
    prev    = cnt8;
    rx_line = 1'b0;
    wait_ticks(320);
    check_val("break_pulses", 32'(cnt8 - prev), 32'd2);
    check_val("break_dout", {24'd0, dout8}, 32'd0);
    check_val("break_ferr", {31'd0, fe8}, 32'd1);
    rx_line = 1'b1;
    wait_ticks(200);
    check_val("break_drain_busy", {31'd0, busy8}, 32'd0);

    // 7 data bits, two stop bits: 8 + 7*16 + 32 ticks to the pulse
    prev = cnt8;
    send_frame(1'b1, 8'h55, 7, 1'b1, 32, -1);
    check_val("v7_pulses", 32'(cnt7), 32'd1);
    check_val("v7_dout", {24'd0, dout7}, 32'h55);
    check_val("v7_msb", {31'd0, dout7[7]}, 32'd0);
    check_val("v7_ferr", {31'd0, fe7}, 32'd0);
    check_val("v7_latency", 32'(tick7_cap - start_tick), 32'd152);
    check_val("v7_other_quiet", 32'(cnt8 - prev), 32'd0);
    sel7 = 1'b0;
    wait_ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
